// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, runs the req/ack handshake with
// instruction memory and holds each fetched word until the datapath takes it.
`timescale 1ns/1ps

module instr_fetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode
);

   localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] target_q, target_d;
   logic            kill_q, kill_d;
   logic            valid_d;
   logic [XLEN-1:0] instr_d, instr_pc_d;
   logic [XLEN-1:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & ALIGN_MASK;
   assign imem_addr        = pc_q;
   assign opcode           = instr[6:0];

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         target_q    <= '0;
         kill_q      <= 1'b0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         target_q    <= target_d;
         kill_q      <= kill_d;
         imem_req    <= (state_d == ST_FETCH);
         instr_valid <= valid_d;
         instr       <= instr_d;
         instr_pc    <= instr_pc_d;
      end
   end

   // Next-state logic; redirect outranks both ack data and stall
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      target_d   = target_q;
      kill_d     = kill_q;
      valid_d    = instr_valid;
      instr_d    = instr;
      instr_pc_d = instr_pc;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            if (redirect) begin
               pc_d = redirect_aligned;
            end
         end

         ST_FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  pc_d   = redirect_aligned;
                  kill_d = 1'b0;
               end else if (kill_q) begin
                  pc_d   = target_q;
                  kill_d = 1'b0;
               end else begin
                  instr_d    = imem_rdata;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  pc_d       = pc_q + STEP;
                  state_d    = ST_FULL;
               end
            end else if (redirect) begin
               // Address must stay put until ack; remember where to go next
               target_d = redirect_aligned;
               kill_d   = 1'b1;
            end
         end

         ST_FULL: begin
            if (redirect) begin
               valid_d = 1'b0;
               pc_d    = redirect_aligned;
               state_d = ST_FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            kill_d  = 1'b0;
         end
      endcase
   end

endmodule
